// File: rtl/wb_pkg.sv
// Shared write-back encodings: result-select and load-type codes.
// Used by the WB register stage and its load extender.
package wb_pkg;

  localparam logic [1:0] WB_SEL_ALU  = 2'b00;
  localparam logic [1:0] WB_SEL_DMEM = 2'b01;
  localparam logic [1:0] WB_SEL_LINK = 2'b10;
  localparam logic [1:0] WB_SEL_AUX  = 2'b11;

  localparam logic [2:0] LD_LW  = 3'b000;
  localparam logic [2:0] LD_LB  = 3'b001;
  localparam logic [2:0] LD_LBU = 3'b010;
  localparam logic [2:0] LD_LH  = 3'b011;
  localparam logic [2:0] LD_LHU = 3'b100;

endpackage

// File: rtl/wb_load_extend.sv
// Sub-word load extraction: picks byte/half by offset and
// sign- or zero-extends it; unknown codes pass the word.
module wb_load_extend
  import wb_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] word,
  input  logic [1:0]        off,
  input  logic [2:0]        load_type,
  output logic [DATA_W-1:0] ext
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Lane select: byte by full offset, half by off[1] only
  always_comb begin
    byte_v = word[7:0];
    case (off)
      2'd0:    byte_v = word[7:0];
      2'd1:    byte_v = word[15:8];
      2'd2:    byte_v = word[23:16];
      default: byte_v = word[31:24];
    endcase
    half_v = off[1] ? word[31:16] : word[15:0];
  end

  // Extension by load type; reserved codes act as LW
  always_comb begin
    ext = word;
    case (load_type)
      LD_LB:   ext = {{(DATA_W-8){byte_v[7]}}, byte_v};
      LD_LBU:  ext = {{(DATA_W-8){1'b0}}, byte_v};
      LD_LH:   ext = {{(DATA_W-16){half_v[15]}}, half_v};
      LD_LHU:  ext = {{(DATA_W-16){1'b0}}, half_v};
      default: ext = word;
    endcase
  end

endmodule

// File: rtl/pipeline_wb_unit.sv
// MEM/WB pipeline register, result mux and retire counter.
// Outputs are combinational functions of the WB registers only.
module pipeline_wb_unit
  import wb_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              valid_in,
  input  logic [ADDR_W-1:0] rd_write_address_in,
  input  logic              rd_write_enable_in,
  input  logic [1:0]        rd_select_in,
  input  logic [2:0]        load_type_in,
  input  logic [1:0]        byte_off_in,
  input  logic [DATA_W-1:0] alu_result_in,
  input  logic [DATA_W-1:0] dmem_data_in,
  input  logic [DATA_W-1:0] link_addr_in,
  input  logic [DATA_W-1:0] aux_data_in,
  output logic [ADDR_W-1:0] rd_write_address_out,
  output logic              rd_write_enable_out,
  output logic [DATA_W-1:0] rd_write_data_out,
  output logic              wb_valid_out,
  output logic [CNT_W-1:0]  retire_count_out
);

  if (DATA_W != 32) begin : g_bad_width
    $error("pipeline_wb_unit: DATA_W must be 32");
  end

  logic              valid_r;
  logic              we_r;
  logic [ADDR_W-1:0] addr_r;
  logic [1:0]        sel_r;
  logic [2:0]        ltype_r;
  logic [1:0]        off_r;
  logic [DATA_W-1:0] alu_r;
  logic [DATA_W-1:0] dmem_r;
  logic [DATA_W-1:0] link_r;
  logic [DATA_W-1:0] aux_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [DATA_W-1:0] load_v;

  // WB register: reset/flush insert a bubble, stall holds
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      valid_r <= 1'b0;
      we_r    <= 1'b0;
      addr_r  <= '0;
      sel_r   <= WB_SEL_ALU;
      ltype_r <= LD_LW;
      off_r   <= '0;
      alu_r   <= '0;
      dmem_r  <= '0;
      link_r  <= '0;
      aux_r   <= '0;
    end else if (!stall) begin
      valid_r <= valid_in;
      we_r    <= rd_write_enable_in;
      addr_r  <= rd_write_address_in;
      sel_r   <= rd_select_in;
      ltype_r <= load_type_in;
      off_r   <= byte_off_in;
      alu_r   <= alu_result_in;
      dmem_r  <= dmem_data_in;
      link_r  <= link_addr_in;
      aux_r   <= aux_data_in;
    end
  end

  // Retire count: the WB instruction leaves on any unstalled edge
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (valid_r && !stall) begin
      cnt_r <= cnt_r + 1'b1;
    end
  end

  wb_load_extend #(
    .DATA_W (DATA_W)
  ) u_ext (
    .word      (dmem_r),
    .off       (off_r),
    .load_type (ltype_r),
    .ext       (load_v)
  );

  // Result mux and x0-suppressed write enable
  always_comb begin
    rd_write_data_out = alu_r;
    case (sel_r)
      WB_SEL_ALU:  rd_write_data_out = alu_r;
      WB_SEL_DMEM: rd_write_data_out = load_v;
      WB_SEL_LINK: rd_write_data_out = link_r;
      default:     rd_write_data_out = aux_r;
    endcase
    rd_write_enable_out  = valid_r & we_r & (addr_r != '0);
    rd_write_address_out = addr_r;
    wb_valid_out         = valid_r;
    retire_count_out     = cnt_r;
  end

endmodule
